// File: rtl/nios2_iteration_sequencer_if.sv
// Avalon-MM register bus between the Nios II master and the iteration sequencer.
interface nios2_iteration_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios2_iteration_sequencer.sv
// One-shot loop controller: runs iter_count start/done handshakes with the compute engine.
// Optional interrupt output is enabled by defining NIOS2_ITER_SEQ_IRQ_EN.
module nios2_iteration_sequencer #(
    parameter int CNT_W = 16,
    parameter int TMO_W = 20
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios2_iteration_sequencer_if.slave   avs,
    input  logic [CNT_W-1:0]             iter_count,
    output logic                         iter_start,
    output logic [CNT_W-1:0]             iter_index,
    input  logic                         iter_done
`ifdef NIOS2_ITER_SEQ_IRQ_EN
    ,
    output logic                         irq
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

    localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   index_q, index_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [TMO_W-1:0]   wdog_q, wdog_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               timeout_q, timeout_d;

    logic               wr_ctrl, wr_stat, start_req, abort_req;
    logic               set_done, set_abort, set_tmo, clr_all;
    logic [2:0]         stat_clr;
    logic [CNT_W-1:0]   index_inc;
    logic               busy;
    logic               irq_mask_rd;

    assign wr_ctrl   = avs.chipselect && !avs.write_n && (avs.address == 2'd0);
    assign wr_stat   = avs.chipselect && !avs.write_n && (avs.address == 2'd1);
    // ABORT in the same write suppresses START
    assign start_req = wr_ctrl && avs.writedata[0] && !avs.writedata[1];
    assign abort_req = wr_ctrl && avs.writedata[1];
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        target_d  = target_q;
        wdog_d    = wdog_q;
        set_done  = 1'b0;
        set_abort = 1'b0;
        set_tmo   = 1'b0;
        clr_all   = 1'b0;
        index_inc = index_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    target_d = iter_count;
                    index_d  = '0;
                    clr_all  = 1'b1;
                    if (iter_count == '0) set_done = 1'b1;
                    else                  state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iter_done) begin
                    index_d = index_inc;
                    if (index_inc == target_q) begin
                        state_d  = S_IDLE;
                        set_done = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_IDLE;
                    set_tmo = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides any completion or timeout decided above; index is frozen
        if (abort_req && busy) begin
            state_d   = S_IDLE;
            index_d   = index_q;
            set_done  = 1'b0;
            set_tmo   = 1'b0;
            set_abort = 1'b1;
        end

        stat_clr  = clr_all ? 3'b111 : (wr_stat ? avs.writedata[3:1] : 3'b000);
        done_d    = (done_q    & ~stat_clr[0]) | set_done;
        aborted_d = (aborted_q & ~stat_clr[1]) | set_abort;
        timeout_d = (timeout_q & ~stat_clr[2]) | set_tmo;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            target_q  <= '0;
            wdog_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            target_q  <= target_d;
            wdog_q    <= wdog_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef NIOS2_ITER_SEQ_IRQ_EN
    logic irq_mask_q, irq_mask_d;
    logic irq_q, irq_d;

    // irq follows next-state status so it drops the cycle right after a W1C
    always_comb begin
        irq_mask_d = wr_ctrl ? avs.writedata[2] : irq_mask_q;
        irq_d      = irq_mask_d & (done_d | aborted_d | timeout_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq         = irq_q;
    assign irq_mask_rd = irq_mask_q;
`else
    assign irq_mask_rd = 1'b0;
`endif

    assign iter_start = (state_q == S_LAUNCH);
    assign iter_index = index_q;

    always_comb begin
        case (avs.address)
            2'd0:    avs.readdata = {29'b0, irq_mask_rd, 2'b0};
            2'd1:    avs.readdata = {28'b0, timeout_q, aborted_q, done_q, busy};
            2'd2:    avs.readdata = 32'(index_q);
            default: avs.readdata = 32'(target_q);
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^avs.writedata[31:4];

endmodule
